// File: rtl/kyber_coef_loader.sv
`timescale 1ns/1ps
// kyber_coef_loader
//   Upstream feeder for the 4-PE Kyber polynomial multiplier. Collects one
//   polynomial of N coefficients from a valid/ready stream, reducing each
//   value once mod Q, then replays it as N/PE_NUMBER packed words in a single
//   burst that is preceded by a one-cycle load strobe on the selected port.
//
// Ports
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   coef_i/coef_vld_i      input coefficient stream (handshake in FILL)
//   coef_rdy_o             high only while collecting a frame
//   tgt_i                  frame target, sampled with coefficient index 0
//                          (0=a_f, 1=a_i, 2=b_f, 3=b_i)
//   flush_i                drop the partially filled frame
//   load_a_f..load_b_i     one-cycle load strobe, exactly one per frame
//   din/din_vld            packed burst word, lane 0 in the LSBs
//   frame_done             one-cycle pulse after the last burst word
//
// PE_NUMBER and N are expected to be powers of two.
module kyber_coef_loader #(
  parameter int PE_NUMBER = 4,
  parameter int N         = 256,
  parameter int Q         = 3329
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [11:0]               coef_i,
  input  logic                      coef_vld_i,
  output logic                      coef_rdy_o,
  input  logic [1:0]                tgt_i,
  input  logic                      flush_i,
  output logic                      load_a_f,
  output logic                      load_a_i,
  output logic                      load_b_f,
  output logic                      load_b_i,
  output logic [12*PE_NUMBER-1:0]   din,
  output logic                      din_vld,
  output logic                      frame_done
);

  localparam int WORDS = N / PE_NUMBER;
  localparam int FW    = $clog2(N);
  localparam int BW    = $clog2(WORDS);
  localparam int LW    = $clog2(PE_NUMBER);

  localparam logic [FW-1:0] FILL_LAST  = FW'(N - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(WORDS - 1);
  localparam logic [11:0]   Q12        = 12'(Q);

  typedef enum logic [1:0] {
    S_FILL,
    S_STROBE,
    S_BURST
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_hs;
  logic [FW-1:0]             r_fill_cnt;
  logic [BW-1:0]             r_burst_cnt;
  logic [1:0]                r_tgt;
  logic [3:0]                r_load;
  logic [12*PE_NUMBER-1:0]   r_din;
  logic                      r_din_vld;
  logic                      r_frame_done;
  logic [11:0]               w_red;
  logic [BW-1:0]             w_rd_idx;
  logic [FW-1:0]             w_base;
  logic [12*PE_NUMBER-1:0]   w_word;
  logic [11:0]               r_mem [N];

  // A 12-bit input is below 2*Q, so one conditional subtract is canonical.
  assign w_red = (coef_i >= Q12) ? (coef_i - Q12) : coef_i;

  // Ready is forced low while reset is held even though the state already
  // sits in FILL.
  assign coef_rdy_o = reset_n & (r_state == S_FILL);

  // ---------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FILL;
    else          r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    w_hs   = 1'b0;
    unique case (r_state)
      S_FILL: begin
        // flush wins over a coincident handshake
        w_hs = coef_vld_i & ~flush_i;
        if (w_hs && (r_fill_cnt == FILL_LAST)) w_next = S_STROBE;
      end
      S_STROBE: w_next = S_BURST;
      S_BURST:  if (r_burst_cnt == BURST_LAST) w_next = S_FILL;
      default:  w_next = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------
  // Coefficient buffer
  // ---------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are always rewritten before
  // they are replayed, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_hs) r_mem[r_fill_cnt] <= w_red;
  end

  // The word registered into din is the one shown in the next cycle:
  // word 0 while in STROBE, word counter+1 while in BURST.
  assign w_rd_idx = (r_state == S_STROBE) ? '0 : r_burst_cnt + 1'b1;
  assign w_base   = {w_rd_idx, LW'(0)};

  always_comb begin
    w_word = '0;
    for (int k = 0; k < PE_NUMBER; k++) begin
      w_word[12*k +: 12] = r_mem[w_base + FW'(k)];
    end
  end

  // ---------------------------------------------------------------------
  // Counters, target latch and registered outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_tgt        <= '0;
      r_load       <= '0;
      r_din        <= '0;
      r_din_vld    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_load       <= '0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_FILL: begin
          if (flush_i) begin
            r_fill_cnt <= '0;
          end else if (w_hs) begin
            if (r_fill_cnt == '0) r_tgt <= tgt_i;
            if (r_fill_cnt == FILL_LAST) begin
              r_fill_cnt <= '0;
              r_load     <= 4'b0001 << r_tgt;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end
        end
        S_STROBE: begin
          r_din       <= w_word;
          r_din_vld   <= 1'b1;
          r_burst_cnt <= '0;
        end
        S_BURST: begin
          if (r_burst_cnt == BURST_LAST) begin
            r_din_vld    <= 1'b0;
            r_frame_done <= 1'b1;
            r_burst_cnt  <= '0;
          end else begin
            r_din       <= w_word;
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_a_f   = r_load[0];
  assign load_a_i   = r_load[1];
  assign load_b_f   = r_load[2];
  assign load_b_i   = r_load[3];
  assign din        = r_din;
  assign din_vld    = r_din_vld;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_kyber_coef_loader.sv
`timescale 1ns/1ps
// Directed bench for kyber_coef_loader: reset, full frames, reduction,
// valid gaps with target change, flush, reset mid-burst, back-to-back frames.
module tb_kyber_coef_loader;

  localparam int PE = 4;
  localparam int N  = 256;
  localparam int W  = N / PE;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [11:0]   coef_i = '0;
  logic          coef_vld_i = 1'b0;
  logic          coef_rdy_o;
  logic [1:0]    tgt_i = '0;
  logic          flush_i = 1'b0;
  logic          load_a_f, load_a_i, load_b_f, load_b_i;
  logic [12*PE-1:0] din;
  logic          din_vld;
  logic          frame_done;
  logic [3:0]    loads;

  int n_cmp = 0;
  int n_bad = 0;
  int tx [N];   // values driven on coef_i
  int ex [N];   // expected reduced values in the buffer

  kyber_coef_loader #(.PE_NUMBER(PE), .N(N), .Q(3329)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coef_i     (coef_i),
    .coef_vld_i (coef_vld_i),
    .coef_rdy_o (coef_rdy_o),
    .tgt_i      (tgt_i),
    .flush_i    (flush_i),
    .load_a_f   (load_a_f),
    .load_a_i   (load_a_i),
    .load_b_f   (load_b_f),
    .load_b_i   (load_b_i),
    .din        (din),
    .din_vld    (din_vld),
    .frame_done (frame_done)
  );

  assign loads = {load_b_i, load_b_f, load_a_i, load_a_f};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12*PE-1:0] exp_word(input int w);
    logic [12*PE-1:0] r;
    r = '0;
    for (int k = 0; k < PE; k++) r[12*k +: 12] = 12'(ex[PE*w + k]);
    return r;
  endfunction

  // Entered and left at posedge+1; returns once the edge with rdy&vld passes.
  task automatic wait_hs();
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = coef_rdy_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("hs_timeout", hs, 1);
  endtask

  task automatic send_range(input int first, input int cnt, input logic [1:0] tg0,
                            input logic [1:0] tgr, input bit gaps);
    for (int i = first; i < first + cnt; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        coef_vld_i = 1'b0;
        coef_i     = 12'hABC;
        tgt_i      = tgr;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      coef_i     = 12'(tx[i]);
      tgt_i      = (i == 0) ? tg0 : tgr;
      coef_vld_i = 1'b1;
      wait_hs();
    end
    coef_vld_i = 1'b0;
  endtask

  // Called at posedge(T)+1 where T is the cycle of the last handshake.
  task automatic check_burst(input int tgt, input string nm);
    logic [3:0] want_ld;
    want_ld = 4'b0001 << tgt;
    @(negedge clk);                              // T+1
    check({nm, "_strobe"}, loads, want_ld);
    check({nm, "_strobe_vld"}, din_vld, 0);
    check({nm, "_strobe_rdy"}, coef_rdy_o, 0);
    for (int w = 0; w < W; w++) begin            // T+2 .. T+65
      @(negedge clk);
      check($sformatf("%s_w%0d", nm, w), din, exp_word(w));
      check($sformatf("%s_vld%0d", nm, w), din_vld, 1);
      check($sformatf("%s_rdy%0d", nm, w), coef_rdy_o, 0);
      check($sformatf("%s_ld%0d", nm, w), loads, 0);
      check($sformatf("%s_done%0d", nm, w), frame_done, 0);
    end
    @(negedge clk);                              // T+66
    check({nm, "_done"}, frame_done, 1);
    check({nm, "_done_rdy"}, coef_rdy_o, 1);
    check({nm, "_done_vld"}, din_vld, 0);
    check({nm, "_done_ld"}, loads, 0);
    @(negedge clk);
    check({nm, "_done_pulse"}, frame_done, 0);
  endtask

  initial begin
    logic act;

    // ---- reset state ----
    #2;
    check("rst_rdy", coef_rdy_o, 0);
    check("rst_vld", din_vld, 0);
    check("rst_ld", loads, 0);
    check("rst_done", frame_done, 0);
    #15 reset_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", coef_rdy_o, 1);
    check("rel_vld", din_vld, 0);
    @(posedge clk); #1;

    // ---- ramp frame, a_f ----
    for (int i = 0; i < N; i++) tx[i] = i;
    ex = tx;
    send_range(0, N, 2'd0, 2'd0, 1'b0);
    check_burst(0, "ramp");
    check("ramp_w0_hand", exp_word(0), 48'h003_002_001_000);
    check("ramp_w63_hand", exp_word(63), {12'd255, 12'd254, 12'd253, 12'd252});
    @(posedge clk); #1;

    // ---- reduction, a_i ----
    for (int i = 0; i < N; i++) tx[i] = i;
    tx[0] = 3328; tx[1] = 3329; tx[2] = 4095; tx[3] = 0;
    ex = tx;
    ex[0] = 3328; ex[1] = 0; ex[2] = 766; ex[3] = 0;
    send_range(0, N, 2'd1, 2'd1, 1'b0);
    check_burst(1, "red");
    @(posedge clk); #1;

    // ---- valid gaps, target 3 then changed to 1 ----
    for (int i = 0; i < N; i++) tx[i] = i;
    ex = tx;
    send_range(0, N, 2'd3, 2'd1, 1'b1);
    check_burst(3, "gap");
    @(posedge clk); #1;

    // ---- flush after 100, coincident handshake dropped ----
    for (int i = 0; i < N; i++) tx[i] = 1000 + i;
    send_range(0, 100, 2'd1, 2'd1, 1'b0);
    flush_i    = 1'b1;
    coef_vld_i = 1'b1;
    coef_i     = 12'd77;
    tgt_i      = 2'd3;
    @(posedge clk); #1;
    flush_i    = 1'b0;
    coef_vld_i = 1'b0;
    for (int i = 0; i < N; i++) tx[i] = 2000 + i;
    ex = tx;
    send_range(0, N, 2'd2, 2'd0, 1'b0);
    check_burst(2, "flush");
    @(posedge clk); #1;

    // ---- reset at burst word 10 ----
    for (int i = 0; i < N; i++) tx[i] = 7 * i;
    ex = tx;
    send_range(0, N, 2'd0, 2'd0, 1'b0);
    repeat (12) @(negedge clk);
    check("mid_w10", din, exp_word(10));
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_vld", din_vld, 0);
    check("mid_rst_rdy", coef_rdy_o, 0);
    check("mid_rst_ld", loads, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_rdy", coef_rdy_o, 1);
    act = 1'b0;
    repeat (80) begin
      @(negedge clk);
      act = act | din_vld | frame_done | (|loads);
    end
    check("mid_quiet", act, 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) tx[i] = 3 * i + 1;
    ex = tx;
    send_range(0, N, 2'd3, 2'd3, 1'b0);
    check_burst(3, "mid_next");
    @(posedge clk); #1;

    // ---- back-to-back: second frame (b_f) starts handshaking at T+66 ----
    for (int i = 0; i < N; i++) tx[i] = i + 500;
    ex = tx;
    send_range(0, N, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < N; i++) tx[i] = (N - 1 - i) * 5;
    fork
      send_range(0, N, 2'd2, 2'd2, 1'b0);
      check_burst(0, "b2b1");
    join
    ex = tx;
    check_burst(2, "b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/kyber_coef_loader.md
Name: kyber_coef_loader

Overview:
- Upstream feeder for the 4-PE Kyber polynomial multiplier top.
- Accepts one 12-bit coefficient per cycle over a valid/ready stream and reduces each to canonical form mod Q.
- Buffers one full polynomial of N coefficients.
- Replays the buffer as N/PE_NUMBER packed words in one contiguous burst, preceded by a one-cycle load strobe on the selected load port.

Parameters:
PE_NUMBER, 4, coefficient lanes per output word
N, 256, coefficients per polynomial
Q, 3329, modulus used for input reduction

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
coef_i  in  12  input coefficient
coef_vld_i  in  1  coefficient valid
coef_rdy_o  out  1  loader can accept coefficient
tgt_i  in  2  target for the frame: 0=a_f, 1=a_i, 2=b_f, 3=b_i; sampled with coefficient index 0
flush_i  in  1  discard the partially filled frame
load_a_f  out  1  load strobe, operand a, forward order
load_a_i  out  1  load strobe, operand a, inverse order
load_b_f  out  1  load strobe, operand b, forward order
load_b_i  out  1  load strobe, operand b, inverse order
din  out  12*PE_NUMBER  packed coefficient word to the multiplier
din_vld  out  1  din carries a burst word
frame_done  out  1  one-cycle pulse when the burst completes

Behaviour:
- Reset (reset_n low, async): state=FILL, fill counter=0, burst counter=0, latched target=0. All outputs are 0 except coef_rdy_o=1 once reset is released; coef_rdy_o is 0 while reset_n is low. Buffer contents are don't-care.
- Reset asserted mid-frame or mid-burst: the operation is abandoned immediately. No strobe or burst word appears after release.
- Reduction: stored value = coef_i - Q if coef_i >= Q, else coef_i. One conditional subtract; 4095 maps to 766.
- Packing: coefficient index i goes to word i/PE_NUMBER, lane i%PE_NUMBER. Lane k occupies din[12k+11:12k], so lane 0 is the LSBs.
- FILL state:
  - coef_rdy_o=1; a handshake occurs when coef_vld_i=1.
  - Each handshake writes the reduced value and increments the fill counter (0..N-1).
  - Handshake at index 0 latches tgt_i; tgt_i is ignored at every other index.
  - Handshake at index N-1 moves to STROBE on the next cycle and wraps the fill counter to 0.
- flush_i in FILL: the fill counter clears to 0 next cycle, and any handshake in the same cycle is dropped (flush wins). flush_i is ignored in STROBE and BURST.
- STROBE state (1 cycle):
  - coef_rdy_o=0.
  - Exactly one of load_a_f/load_a_i/load_b_f/load_b_i is high, per the latched target.
  - din_vld=0. Next state is BURST.
- BURST state (N/PE_NUMBER cycles):
  - coef_rdy_o=0, din_vld=1.
  - din = word[burst counter], counter runs 0..N/PE_NUMBER-1.
  - After the last word, return to FILL.
- Registered outputs: din, din_vld, load_* and frame_done are all registered.
- Latency: if the last coefficient is accepted at cycle T:
  - load strobe at T+1;
  - words 0..63 at T+2..T+65;
  - frame_done=1 and coef_rdy_o=1 at T+66.
  - A new frame can begin handshaking at T+66.
- din holds its last value when din_vld=0 (value not checked).
- At most one load_* output is high in any cycle.

Test Plan:
- Reset, then 256 coefficients with values 0..255, tgt_i=0, coef_vld_i held high → load_a_f pulse at T+1. din at T+2 = {12'd3,12'd2,12'd1,12'd0}. Word 63 = {255,254,253,252}. frame_done at T+66.
- Reduction: coefficients 3328, 3329, 4095, 0 as indices 0..3 → word 0 = {0,766,0,3328}.
- Gaps and target: random coef_vld_i gaps with tgt_i=3 at index 0 and changed to 1 afterwards → load_b_i pulses only, and the word sequence is identical to the gap-free case.
- Flush: flush_i after 100 coefficients, then a fresh 256-coefficient frame → only the fresh data appears. A handshake coincident with flush_i is dropped.
- Reset mid-burst: reset_n low at burst word 10 → din_vld=0, no frame_done, no further load_*. coef_rdy_o=1 after release, and the next full frame replays correctly.
- Back-to-back frames: second frame with tgt_i=2 starts at T+66 → coef_rdy_o stays 0 through STROBE/BURST, and the second burst uses a load_b_f strobe.
